// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Multiplexed 7-segment display driver. Lights one digit at a time for
// REFRESH_DIV clock cycles, stepping through NUM_DIGITS digits per frame.
// Each digit shows one hex nibble, its own decimal point, and can be blanked
// when it is a leading zero. New values are double-buffered, so a frame never
// mixes old and new digits.
//
// Parameters
//   NUM_DIGITS   digits scanned (>= 1); digit 0 shows the least significant nibble
//   REFRESH_DIV  clk cycles each digit stays lit (>= 2)
//   ACTIVE_LOW   1: an/out are low-true, 0: high-true
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   value       in   [4*NUM_DIGITS-1:0] hex value, nibble k shows on digit k
//   dp          in   [NUM_DIGITS-1:0] decimal point per digit, 1 = lit
//   blank_zero  in   1 = blank leading-zero digits
//   load        in   1-cycle strobe, captures value/dp/blank_zero
//   an          out  [NUM_DIGITS-1:0] digit anode enables (registered)
//   out         out  [7:0] segments {dp,g,f,e,d,c,b,a} (registered)
//   frame_done  out  1-cycle pulse the cycle after each frame boundary
//
// Load protocol: load has no back-pressure. Every cycle with load=1 is taken
// as a new request; the captured data waits in a shadow buffer until the next
// frame boundary, and a later load before that boundary replaces it. A load
// on the boundary cycle itself goes straight to the display registers.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_zero,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              out,
    output logic                    frame_done
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // XOR masks that turn high-true patterns into the pin polarity; they are
    // also the "everything off" pattern used at reset.
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]            OUT_POL = {8{ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TICK_W-1:0]       tick_q,   tick_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic                    pend_q,   pend_d;

    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q,  sh_dp_d;
    logic                    sh_bz_q,  sh_bz_d;

    logic [4*NUM_DIGITS-1:0] ds_val_q, ds_val_d;
    logic [NUM_DIGITS-1:0]   ds_dp_q,  ds_dp_d;
    logic                    ds_bz_q,  ds_bz_d;

    logic [NUM_DIGITS-1:0]   an_q,     an_d;
    logic [7:0]              out_q,    out_d;
    logic                    fd_q,     fd_d;

    logic                    tick_wrap;
    logic                    boundary;

    // ------------------------------------------------------------------
    // Scan counters and frame boundary
    // ------------------------------------------------------------------
    always_comb begin
        tick_wrap = (tick_q == TICK_LAST);
        boundary  = tick_wrap && (idx_q == IDX_LAST);

        tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);

        idx_d = idx_q;
        if (tick_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: shadow collects loads, display changes only at a
    // frame boundary.
    // ------------------------------------------------------------------
    always_comb begin
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_bz_d  = sh_bz_q;
        ds_val_d = ds_val_q;
        ds_dp_d  = ds_dp_q;
        ds_bz_d  = ds_bz_q;
        pend_d   = pend_q;

        if (load) begin
            sh_val_d = value;
            sh_dp_d  = dp;
            sh_bz_d  = blank_zero;
        end

        if (boundary) begin
            // A load landing on the boundary is newer than anything in the
            // shadow, so it bypasses the shadow and leaves nothing pending.
            if (load) begin
                ds_val_d = value;
                ds_dp_d  = dp;
                ds_bz_d  = blank_zero;
            end else if (pend_q) begin
                ds_val_d = sh_val_q;
                ds_dp_d  = sh_dp_q;
                ds_bz_d  = sh_bz_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking, from the display registers only.
    // lit[k] is set when digit k is 0, blanking is off, or some nibble at or
    // above k is nonzero.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lit;

    always_comb begin : blank_scan
        logic seen_nz;
        seen_nz = 1'b0;
        lit     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen_nz = seen_nz | (ds_val_q[4*k +: 4] != 4'h0);
            lit[k]  = !ds_bz_q || (k == 0) || seen_nz;
        end
    end

    // ------------------------------------------------------------------
    // Current digit select and hex decode
    // ------------------------------------------------------------------
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lit;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] an_hi;
    logic [7:0]            out_hi;

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lit = 1'b0;
        an_hi   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib  = ds_val_q[4*k +: 4];
                cur_dp   = ds_dp_q[k];
                cur_lit  = lit[k];
                an_hi[k] = lit[k];
            end
        end
    end

    // Segment patterns, high-true, bit order gfedcba.
    always_comb begin
        cur_seg = 7'h00;
        case (cur_nib)
            4'h0: cur_seg = 7'h3F;
            4'h1: cur_seg = 7'h06;
            4'h2: cur_seg = 7'h5B;
            4'h3: cur_seg = 7'h4F;
            4'h4: cur_seg = 7'h66;
            4'h5: cur_seg = 7'h6D;
            4'h6: cur_seg = 7'h7D;
            4'h7: cur_seg = 7'h07;
            4'h8: cur_seg = 7'h7F;
            4'h9: cur_seg = 7'h6F;
            4'hA: cur_seg = 7'h77;
            4'hB: cur_seg = 7'h7C;
            4'hC: cur_seg = 7'h39;
            4'hD: cur_seg = 7'h5E;
            4'hE: cur_seg = 7'h79;
            4'hF: cur_seg = 7'h71;
            default: cur_seg = 7'h00;
        endcase
    end

    always_comb begin
        // A blanked digit turns off the decimal point as well.
        out_hi = cur_lit ? {cur_dp, cur_seg} : 8'h00;
        an_d   = an_hi  ^ AN_POL;
        out_d  = out_hi ^ OUT_POL;
        fd_d   = boundary;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q   <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_bz_q  <= 1'b0;
            ds_val_q <= '0;
            ds_dp_q  <= '0;
            ds_bz_q  <= 1'b0;
            an_q     <= AN_POL;
            out_q    <= OUT_POL;
            fd_q     <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            sh_bz_q  <= sh_bz_d;
            ds_val_q <= ds_val_d;
            ds_dp_q  <= ds_dp_d;
            ds_bz_q  <= ds_bz_d;
            an_q     <= an_d;
            out_q    <= out_d;
            fd_q     <= fd_d;
        end
    end

    assign an         = an_q;
    assign out        = out_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Two instances: "a" (4 digits, low-true) and "b" (8 digits, high-true), both
// with a 4-cycle refresh divider. A reference model at the clock edge computes
// what every cycle should look like from cycle position and the loaded
// values, pushes it into a per-instance queue, and a monitor on the falling
// edge pops and compares against the pins.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT a ----------------
    logic [15:0] value_a = '0;
    logic [3:0]  dp_a    = '0;
    logic        bz_a    = 1'b0;
    logic        load_a  = 1'b0;
    logic [3:0]  an_a;
    logic [7:0]  out_a;
    logic        fd_a;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .value(value_a), .dp(dp_a), .blank_zero(bz_a),
        .load(load_a), .an(an_a), .out(out_a), .frame_done(fd_a)
    );

    // ---------------- DUT b ----------------
    logic [31:0] value_b = '0;
    logic [7:0]  dp_b    = '0;
    logic        bz_b    = 1'b0;
    logic        load_b  = 1'b0;
    logic [7:0]  an_b;
    logic [7:0]  out_b;
    logic        fd_b;

    seg7_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .value(value_b), .dp(dp_b), .blank_zero(bz_b),
        .load(load_b), .an(an_b), .out(out_b), .frame_done(fd_b)
    );

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q_a[$];
    logic [16:0] exp_q_b[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expected {frame_done, an (zero-extended to 8), out} for one cycle.
    function automatic logic [16:0] exp_word(input int nd, input bit al, input logic [31:0] v,
                                             input logic [7:0] d, input logic bz, input int dig,
                                             input logic fd);
        logic [31:0] upper;
        logic [7:0]  mask, an_v, seg_v;
        bit          blank;
        upper = v >> (4 * dig);
        blank = bz && (dig > 0) && (upper == 32'h0);
        mask  = 8'((1 << nd) - 1);
        an_v  = blank ? 8'h00 : 8'(1 << dig);
        seg_v = blank ? 8'h00 : {d[dig], hex_seg(upper[3:0])};
        if (al) begin
            an_v  = ~an_v & mask;
            seg_v = ~seg_v;
        end
        return {fd, an_v, seg_v};
    endfunction

    int          m_n[2];
    logic [31:0] m_val[2], sh_val[2];
    logic [7:0]  m_dp[2],  sh_dp[2];
    logic        m_bz[2],  sh_bz[2], m_pend[2];

    int          md_nd, md_dig;
    bit          md_al, md_bnd;
    logic [31:0] md_iv;
    logic [7:0]  md_idp, md_mask;
    logic        md_ibz, md_il;
    logic [16:0] md_w;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            md_nd = (i == 0) ? 4 : 8;
            md_al = (i == 0);
            if (i == 0) begin
                md_iv = {16'h0, value_a}; md_idp = {4'h0, dp_a}; md_ibz = bz_a; md_il = load_a;
            end else begin
                md_iv = value_b; md_idp = dp_b; md_ibz = bz_b; md_il = load_b;
            end
            if (rst) begin
                m_n[i] = 0; m_pend[i] = 1'b0;
                m_val[i] = '0; m_dp[i] = '0; m_bz[i] = 1'b0;
                sh_val[i] = '0; sh_dp[i] = '0; sh_bz[i] = 1'b0;
                md_mask = 8'((1 << md_nd) - 1);
                md_w = {1'b0, md_al ? md_mask : 8'h00, md_al ? 8'hFF : 8'h00};
            end else begin
                md_dig = (m_n[i] / DIV) % md_nd;
                md_bnd = (m_n[i] % (DIV * md_nd)) == (DIV * md_nd - 1);
                md_w = exp_word(md_nd, md_al, m_val[i], m_dp[i], m_bz[i], md_dig, md_bnd);
                if (md_bnd) begin
                    if (md_il) begin
                        m_val[i] = md_iv; m_dp[i] = md_idp; m_bz[i] = md_ibz;
                    end else if (m_pend[i]) begin
                        m_val[i] = sh_val[i]; m_dp[i] = sh_dp[i]; m_bz[i] = sh_bz[i];
                    end
                    m_pend[i] = 1'b0;
                end
                if (md_il) begin
                    sh_val[i] = md_iv; sh_dp[i] = md_idp; sh_bz[i] = md_ibz;
                    if (!md_bnd) m_pend[i] = 1'b1;
                end
                m_n[i] = m_n[i] + 1;
            end
            if (i == 0) exp_q_a.push_back(md_w);
            else        exp_q_b.push_back(md_w);
        end
    end

    // ---------------- monitor ----------------
    logic [16:0] mon_exp, mon_act;

    always @(negedge clk) begin
        if (exp_q_a.size() > 0) begin
            mon_exp = exp_q_a.pop_front();
            mon_act = {fd_a, 4'h0, an_a, out_a};
            checks++;
            if (mon_act !== mon_exp)  begin
                errors++;
                $display("FAIL scan_a t=%0t got fd/an/out=%b/%b/%h exp=%b/%b/%h",
                         $time, mon_act[16], mon_act[11:8], mon_act[7:0],
                         mon_exp[16], mon_exp[11:8], mon_exp[7:0]);
            end
        end
        if (exp_q_b.size() > 0) begin
            mon_exp = exp_q_b.pop_front();
            mon_act = {fd_b, an_b, out_b};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL scan_b t=%0t got fd/an/out=%b/%b/%h exp=%b/%b/%h",
                         $time, mon_act[16], mon_act[15:8], mon_act[7:0],
                         mon_exp[16], mon_exp[15:8], mon_exp[7:0]);
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_a_t(input logic [15:0] v, input logic [3:0] d, input logic b);
        value_a = v; dp_a = d; bz_a = b; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        // Scramble the live inputs: only the captured copy may matter now.
        value_a = 16'($urandom); dp_a = 4'($urandom); bz_a = 1'($urandom);
    endtask

    task automatic load_b_t(input logic [31:0] v, input logic [7:0] d, input logic b);
        value_b = v; dp_b = d; bz_b = b; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        value_b = $urandom; dp_b = 8'($urandom); bz_b = 1'($urandom);
    endtask

    // Wait until the next rising edge of instance a is at cycle 'ph' of its frame.
    task automatic wait_phase_a(input int ph);
        int budget;
        budget = 64;
        while (((m_n[0] % (DIV * 4)) != ph) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL wait_phase_a got=timeout exp=phase %0d", ph);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] rv;
    int          nk;

    initial begin
        @(negedge clk);
        do_reset(3);
        run(10);
        // Reset held mid-scan, then released.
        do_reset(2);
        run(6);

        // Plain value, then a mid-frame reload that must wait for the boundary.
        load_a_t(16'h1234, 4'h0, 1'b0);
        run(40);
        wait_phase_a(5);
        load_a_t(16'hABCD, 4'h0, 1'b0);
        run(40);

        // Leading-zero blanking.
        load_a_t(16'h0050, 4'h0, 1'b1);
        run(40);
        load_a_t(16'h0000, 4'h0, 1'b1);
        run(40);

        // Load exactly on the boundary cycle, then a double load before a boundary.
        wait_phase_a(15);
        load_a_t(16'h00F0, 4'h0, 1'b0);
        run(40);
        wait_phase_a(2);
        load_a_t(16'h1111, 4'hF, 1'b0);
        load_a_t(16'h2222, 4'h5, 1'b0);
        run(40);

        // High-true 8-digit instance.
        load_b_t(32'h0, 8'h01, 1'b0);
        run(70);

        // Randomised traffic.
        for (int it = 0; it < 80; it++) begin
            rv = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) begin
                nk = $urandom_range(0, 4);
                rv = rv & ((64'h1 << (4 * nk)) - 64'h1);
                if ($urandom_range(0, 3) == 0) wait_phase_a(15);
                load_a_t(rv[15:0], 4'($urandom), 1'($urandom));
            end else begin
                nk = $urandom_range(0, 8);
                rv = rv & ((64'h1 << (4 * nk)) - 64'h1);
                load_b_t(rv[31:0], 8'($urandom), 1'($urandom));
            end
            run($urandom_range(0, 30));
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
        end
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
